// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between requesters, the uart_tx_arb arbiter and the
// transmit serializer byte port.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 err_len;
  logic                 err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data,
    input  grant, busy, err_len, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data,
    output grant, busy, err_len, err_timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet-locked arbiter for one UART TX byte port.
// Define UART_ARB_TIMEOUT_EN to build the stall watchdog.
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  if (NUM_REQ < 2 || MAX_LEN < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
  end

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_len_q, err_len_d;

  logic [NUM_REQ-1:0] sel_oh;
  logic               found;
  logic [IW-1:0]      rr_next;
  logic [7:0]         tx_data;
  logic               owner_last;
  logic               xfer;
  logic               len_hit;

  // First valid requester at or above rr_q, wrapping.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i] &&
            ((int'(rr_q) + k) % NUM_REQ) == i) begin
          sel_oh[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_next    = rr_q;
    tx_data    = 8'h00;
    owner_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        rr_next    = IW'((i + 1) % NUM_REQ);
        tx_data    = bus.req_data[8*i +: 8];
        owner_last = bus.req_last[i];
      end
    end
  end

  assign bus.tx_valid  = |(grant_q & bus.req_valid);
  assign bus.tx_data   = tx_data;
  assign bus.req_ready = grant_q & {NUM_REQ{bus.tx_ready}};
  assign bus.grant     = grant_q;
  assign bus.busy      = |grant_q;
  assign bus.err_len   = err_len_q;

  assign xfer    = bus.tx_valid & bus.tx_ready;
  assign len_hit = (cnt_q == 8'(MAX_LEN - 1));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          to_q, to_d;
  logic          to_hit;

  assign to_hit = (state_q == LOCK) && !xfer &&
                  (stall_q == SW'(TIMEOUT_CYC - 1));

  always_comb begin
    stall_d = '0;
    if (state_q == LOCK && !xfer && !to_hit)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      stall_q <= stall_d;
      to_q    <= to_d;
    end
  end

  assign bus.err_timeout = to_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    err_len_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    to_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel_oh;
          cnt_d   = 8'h00;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'h01;
          // A last on the MAX_LEN-th byte is a clean release.
          if (owner_last || len_hit) begin
            grant_d   = '0;
            state_d   = IDLE;
            rr_d      = rr_next;
            err_len_d = !owner_last;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_hit) begin
          grant_d = '0;
          state_d = IDLE;
          rr_d    = rr_next;
          to_d    = 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= 8'h00;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: packets, round robin, length
// guard, backpressure, watchdog (when built) and async reset.
module tb_uart_tx_arb;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  uart_tx_arb_if #(.NUM_REQ(N)) bus ();

  uart_tx_arb #(
    .NUM_REQ    (N),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setreq(input int i, input logic v,
                        input logic [7:0] d, input logic l);
    bus.req_valid[i]       = v;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]        = l;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
  endtask

  logic [3:0] exp_g [11];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();

    // reset state
    @(negedge clk); #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_txv", 32'(bus.tx_valid), 0);
    chk("rst_rdy", 32'(bus.req_ready), 0);
    chk("rst_elen", 32'(bus.err_len), 0);
    chk("rst_eto", 32'(bus.err_timeout), 0);
    @(negedge clk); rst = 1'b0;

    // requester 2: 41 42 43(last)
    @(negedge clk); setreq(2, 1, 8'h41, 0); #1;
    chk("t1_idle", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("t1_grant", 32'(bus.grant), 32'h4);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_b0", 32'(bus.tx_data), 32'h41);
    chk("t1_rdy", 32'(bus.req_ready), 32'h4);
    @(negedge clk); setreq(2, 1, 8'h42, 0); #1;
    chk("t1_b1", 32'(bus.tx_data), 32'h42);
    @(negedge clk); setreq(2, 1, 8'h43, 1); #1;
    chk("t1_b2", 32'(bus.tx_data), 32'h43);
    chk("t1_g2", 32'(bus.grant), 32'h4);
    @(negedge clk); idle_inputs(); #1;
    chk("t1_rel", 32'(bus.grant), 0);
    chk("t1_relbusy", 32'(bus.busy), 0);
    chk("t1_elen", 32'(bus.err_len), 0);

    // round robin 0,1,3 after fresh reset
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8,
              4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
    setreq(0, 1, 8'h10, 1);
    setreq(1, 1, 8'h11, 1);
    setreq(3, 1, 8'h13, 1);
    #1;
    chk("rr_g0", 32'(bus.grant), 32'(exp_g[0]));
    for (int s = 1; s < 11; s++) begin
      @(negedge clk); #1;
      chk($sformatf("rr_g%0d", s), 32'(bus.grant), 32'(exp_g[s]));
      if (s % 2 == 1)
        chk($sformatf("rr_d%0d", s), 32'(bus.tx_data),
            (exp_g[s] == 4'h8) ? 32'h13 :
            (exp_g[s] == 4'h2) ? 32'h11 : 32'h10);
    end
    @(negedge clk); #1;
    chk("rr_g11", 32'(bus.grant), 32'h8);
    @(negedge clk); idle_inputs(); #1;
    chk("rr_end", 32'(bus.grant), 0);

    // requester 1 streams 20 bytes, MAX_LEN 16
    setreq(1, 1, 8'hA0, 0); #1;
    chk("ml_idle", 32'(bus.grant), 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); setreq(1, 1, 8'(8'hA0 + k), 0); #1;
      chk($sformatf("ml_g%0d", k), 32'(bus.grant), 32'h2);
      chk($sformatf("ml_d%0d", k), 32'(bus.tx_data), 32'(8'hA0 + k));
      chk($sformatf("ml_e%0d", k), 32'(bus.err_len), 0);
    end
    @(negedge clk); setreq(1, 1, 8'hB0, 0); #1;
    chk("ml_rel", 32'(bus.grant), 0);
    chk("ml_elen", 32'(bus.err_len), 1);
    for (int k = 16; k < 20; k++) begin
      @(negedge clk); setreq(1, 1, 8'(8'hA0 + k), k == 19); #1;
      chk($sformatf("ml_g%0d", k), 32'(bus.grant), 32'h2);
      chk($sformatf("ml_d%0d", k), 32'(bus.tx_data), 32'(8'hA0 + k));
      chk($sformatf("ml_e%0d", k), 32'(bus.err_len), 0);
    end
    @(negedge clk); idle_inputs(); #1;
    chk("ml_end", 32'(bus.grant), 0);
    chk("ml_endelen", 32'(bus.err_len), 0);

    // backpressure on owner 0 while requester 2 waits
    setreq(0, 1, 8'hC0, 0); #1;
    @(negedge clk); #1;
    chk("bp_grant", 32'(bus.grant), 32'h1);
    chk("bp_d0", 32'(bus.tx_data), 32'hC0);
    @(negedge clk);
    setreq(0, 1, 8'hC1, 0);
    setreq(2, 1, 8'hD0, 1);
    bus.tx_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      chk($sformatf("bp_hold%0d", s), 32'(bus.grant), 32'h1);
      chk($sformatf("bp_rdy%0d", s), 32'(bus.req_ready), 0);
      chk($sformatf("bp_d1_%0d", s), 32'(bus.tx_data), 32'hC1);
    end
    @(negedge clk); bus.tx_ready = 1'b1; #1;
    chk("bp_resume", 32'(bus.req_ready), 32'h1);
    chk("bp_d1", 32'(bus.tx_data), 32'hC1);
    @(negedge clk); setreq(0, 1, 8'hC2, 1); #1;
    chk("bp_d2", 32'(bus.tx_data), 32'hC2);
    chk("bp_g2", 32'(bus.grant), 32'h1);
    @(negedge clk); setreq(0, 0, 8'h00, 0); #1;
    chk("bp_gap", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("bp_g_r2", 32'(bus.grant), 32'h4);
    chk("bp_d_r2", 32'(bus.tx_data), 32'hD0);
    @(negedge clk); idle_inputs(); #1;
    chk("bp_end", 32'(bus.grant), 0);

    // owner 3 stalls mid-packet
    setreq(3, 1, 8'hE0, 0); #1;
    @(negedge clk); #1;
    chk("st_grant", 32'(bus.grant), 32'h8);
    chk("st_d0", 32'(bus.tx_data), 32'hE0);
    @(negedge clk);
    setreq(3, 0, 8'hE1, 0);
    setreq(0, 1, 8'h55, 1);
    #1;
    chk("st_hold0", 32'(bus.grant), 32'h8);
    for (int s = 1; s < 8; s++) begin
      @(negedge clk); #1;
      chk($sformatf("st_hold%0d", s), 32'(bus.grant), 32'h8);
      chk($sformatf("st_txv%0d", s), 32'(bus.tx_valid), 0);
    end
`ifdef UART_ARB_TIMEOUT_EN
    @(negedge clk); #1;
    chk("to_rel", 32'(bus.grant), 0);
    chk("to_pulse", 32'(bus.err_timeout), 1);
    @(negedge clk); #1;
    chk("to_next", 32'(bus.grant), 32'h1);
    chk("to_clr", 32'(bus.err_timeout), 0);
    chk("to_d", 32'(bus.tx_data), 32'h55);
    @(negedge clk); idle_inputs(); #1;
    chk("to_end", 32'(bus.grant), 0);
`else
    repeat (4) @(negedge clk);
    #1;
    chk("nto_hold", 32'(bus.grant), 32'h8);
    chk("nto_eto", 32'(bus.err_timeout), 0);
    @(negedge clk); setreq(3, 1, 8'hE1, 1); #1;
    chk("nto_d", 32'(bus.tx_data), 32'hE1);
    @(negedge clk); idle_inputs(); #1;
    chk("nto_end", 32'(bus.grant), 0);
`endif

    // async reset mid-packet from owner 1
    @(negedge clk); setreq(1, 1, 8'hF0, 0); #1;
    chk("ar_idle", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("ar_grant", 32'(bus.grant), 32'h2);
    chk("ar_d0", 32'(bus.tx_data), 32'hF0);
    @(negedge clk);
    setreq(1, 1, 8'hF1, 0);
    setreq(0, 1, 8'h01, 1);
    setreq(3, 1, 8'h03, 1);
    #1;
    chk("ar_rdy", 32'(bus.req_ready), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("ar_g0", 32'(bus.grant), 0);
    chk("ar_txv0", 32'(bus.tx_valid), 0);
    chk("ar_rdy0", 32'(bus.req_ready), 0);
    chk("ar_busy0", 32'(bus.busy), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("ar_after", 32'(bus.grant), 0);
    @(negedge clk); #1;
    chk("ar_restart", 32'(bus.grant), 32'h1);
    chk("ar_rd", 32'(bus.tx_data), 32'h01);
    @(negedge clk); idle_inputs(); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin, packet-locked arbiter that shares one UART transmitter byte port among `NUM_REQ` requesters. It sits between the requesting blocks (command responders, status reporters, debug taps) and the transmit serializer, on the same `clk` domain as the receive path. A grant is held for a whole packet, ended by `req_last`, so bytes from different requesters never interleave on the line. A length guard, and optionally a stall watchdog, keep a faulty requester from locking the transmitter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_LEN`, 16: maximum bytes per packet before a forced release, 1..255.
- `TIMEOUT_CYC`, 1024: stall watchdog limit in `clk` cycles. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_data` in `8*NUM_REQ`: requester i's byte occupies `[8i+7:8i]`.
- `req_last` in `NUM_REQ`: marks the final byte of a packet.
- `req_ready` out `NUM_REQ`: byte accepted when `req_valid[i] & req_ready[i]`.
- `tx_valid` out 1: byte valid toward the transmitter.
- `tx_data` out 8: byte toward the transmitter.
- `tx_ready` in 1: transmitter accepts `tx_data` this cycle.
- `grant` out `NUM_REQ`: one-hot current owner, all zero when idle.
- `busy` out 1: a grant is held.
- `err_len` out 1: one-cycle pulse on a forced release due to `MAX_LEN`.
- `err_timeout` out 1: one-cycle pulse on a watchdog release. Tied 0 without the macro.

## Operation
State machine with two states, IDLE and LOCK.
- IDLE:
  - If any `req_valid` is set, select the first set bit scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register the one-hot selection into `grant`, clear `byte_cnt`, go to LOCK.
  - If no `req_valid` is set, stay in IDLE.
- LOCK datapath, combinational from the registered `grant`:
  - `tx_valid = |(grant & req_valid)`.
  - `tx_data` = `req_data` slice of the granted index.
  - `req_ready = grant & {NUM_REQ{tx_ready}}`.
- Transfer: `tx_valid & tx_ready`. Each transfer increments `byte_cnt`, 8 bits wide and saturating.
- Transfer with `req_last` of the owner set:
  - Clear `grant`, go to IDLE.
  - `rr_ptr <=` owner index + 1, modulo `NUM_REQ`.
- Transfer without `req_last` where `byte_cnt` reaches `MAX_LEN`:
  - Forced release with the same pointer update as a normal release.
  - Pulse `err_len`. Later bytes from that requester start a new packet.
- `req_last` on the `MAX_LEN`-th byte is a normal release with no `err_len`.
- An owner that drops `req_valid` mid-packet keeps the grant; `tx_valid` stays 0.
- Requests from non-owners are ignored; their `req_ready` stays 0.
- `busy = |grant`.

## Timing
- Reset values: `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `err_len`=0, `err_timeout`=0, `rr_ptr`=0, `byte_cnt`=0, state IDLE.
- `tx_data` is don't-care while `tx_valid`=0.
- `rst` asserted mid-packet clears all state immediately, independent of `clk`. The in-flight byte is not acknowledged.
- Arbitration latency: `req_valid` seen in an IDLE cycle T gives `grant`, `busy` and a possible first transfer in cycle T+1.
- Back-to-back packets: last transfer in cycle T, IDLE in T+1, next owner granted in T+2. The minimum gap is exactly one dead cycle.
- Steady state within a packet: one byte per cycle while `tx_ready` and `req_valid` are both 1.
- `err_len` and `err_timeout` assert in the cycle after the releasing event, together with `grant` returning to 0.
- Single requester: same index re-granted after the one dead cycle.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A stall counter runs in LOCK, counts cycles without a transfer, and clears on every transfer.
  - When it reaches `TIMEOUT_CYC`: forced release, pointer advance, one-cycle `err_timeout` pulse.
- Undefined: no stall counter is built and `err_timeout` is tied 0. A stalled owner holds the grant indefinitely.

## Test plan
- Reset, then requester 2 sends 3 bytes {0x41, 0x42, 0x43 with last}, `tx_ready`=1:
  - `grant`=4'b0100 one cycle after `req_valid`.
  - `tx_data` sequence 0x41, 0x42, 0x43 on consecutive cycles.
  - `grant`=0 the next cycle.
- Requesters 0, 1 and 3 all hold 1-byte packets continuously:
  - Grant order 0, 1, 3, 0, 1, 3.
  - Exactly one dead cycle between grants.
- Requester 1 streams 20 bytes without `req_last`, `MAX_LEN`=16:
  - 16 bytes accepted, then `err_len` pulse.
  - Requester 1 re-granted after the dead cycle, since it is the only requester.
- During requester 0's packet, `tx_ready` is held 0 for 5 cycles while requester 2 asserts `req_valid`:
  - `grant` remains 4'b0001.
  - `req_ready[2]`=0 throughout.
  - No byte loss or duplication.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=8, owner 3 drops `req_valid` mid-packet:
  - Release after 8 idle cycles with an `err_timeout` pulse.
  - Requester 0 is granted next.
- Assert `rst` mid-packet:
  - `grant`, `tx_valid` and `req_ready` go to 0 asynchronously.
  - After release, arbitration restarts from index 0.
